noc_node: RTL and testbench
===========================

Name: noc_node

Overview:
- Five-port mesh router node (N/S/E/W links plus a local ejection port) with wormhole switching and dimension-order routing.
- A header flit reserves an output for the whole packet; the following body and tail flits stream through.
- Instantiated once per mesh tile; neighbouring nodes connect out_* of one node to in_* of the other.

Parameters:
- X_POS, 1, row coordinate of this node (x grows toward SOUTH)
- Y_POS, 1, column coordinate of this node (y grows toward EAST)
- ADDR_W, 4, width of each address coordinate
- LEN_W, 4, width of the tail_length field
- PAYLOAD_W, 30, flit payload width (must be >= 2*ADDR_W+LEN_W)
- BUF_DEPTH, 2, input FIFO depth per link port (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- in_flit_i  in  4x(2+PAYLOAD_W)  incoming flit per direction; index NORTH=0, SOUTH=1, EAST=2, WEST=3
- in_enable_i  in  4  incoming flit valid
- in_ack_o  out  4  node can accept a flit on that input
- out_flit_o  out  4x(2+PAYLOAD_W)  outgoing flit per direction
- out_enable_o  out  4  outgoing flit valid
- out_ack_i  in  4  neighbour can accept
- local_flit_o  out  2+PAYLOAD_W  ejected flit
- local_enable_o  out  1  ejected flit valid
- local_ack_i  in  1  local sink ready
- err_o  out  1  sticky protocol error

Behaviour:
- Flit format: [PAYLOAD_W+1:PAYLOAD_W] = flit_type (HEADER=01, BODY=10, TAIL=11, 00 invalid), [PAYLOAD_W-1:0] = payload.
- Header payload: dst_x = [2A+L-1:A+L], dst_y = [A+L-1:L], tail_length = [L-1:0], where A=ADDR_W and L=LEN_W. tail_length is the number of flits following the header.
- Transfer rule: a transfer happens on a rising edge where enable=1 and ack=1, on any link.
- in_ack_o[d] = FIFO[d] count < BUF_DEPTH. It depends only on registered state; there is no combinational path from out_ack_i.
- When a FIFO is full, a push and a pop in the same cycle are not possible: ack is already 0.
- Routing is computed on the head HEADER of each input FIFO, Y first then X:
  - dst_y > Y_POS -> EAST; dst_y < Y_POS -> WEST
  - otherwise dst_x > X_POS -> SOUTH; dst_x < X_POS -> NORTH
  - otherwise -> LOCAL
  - All comparisons are unsigned.
- Arbitration: each output (4 links + LOCAL) has a round-robin arbiter over the 4 inputs. The priority pointer starts at NORTH and moves to the input after the winner on each grant.
- A grant locks input->output until header + tail_length flits have left. The lock releases on the edge the last flit transfers, and a new header may be granted the next cycle.
- Flit type is not checked against the count; the length field alone governs release.
- Output path: out_enable = granted input FIFO non-empty; out_flit = that FIFO's head (combinational crossbar). FIFO pops when the output ack is high.
- Latency: a flit accepted at edge k is presented on the output in cycle k+1 if the path is free.
- A non-HEADER flit (or type 00) at the head of an unlocked input is popped, discarded and sets err_o. Only reset clears err_o.
- Inputs do not bypass each other: head-of-line blocking per input is accepted.
- Reset (rst=0 at an edge):
  - FIFOs emptied, locks and length counters cleared, RR pointers reset to NORTH, err_o=0.
  - While rst=0: all out_enable_o=0, out_flit_o=0, local_enable_o=0, in_ack_o=0.
  - A packet in flight when reset is asserted is dropped entirely.

Optional Feature:
PKT_CNT_EN
- Defined: adds output port pkt_cnt_o, 5x16, one counter per output (N,S,E,W,LOCAL). Each counter increments on every HEADER transfer out of that output, wraps at 16'hFFFF->0, and is cleared by reset.
- Undefined: the port and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> in_ack_o=0000, out_enable_o=0000, err_o=0. After rst=1 -> in_ack_o=1111.
- Header on WEST with dst(1,3), tail_length=3, all out_ack_i=1 -> out_enable_o[EAST]=1 next cycle carrying the identical flit. The 3 following flits appear on EAST on consecutive cycles, then the EAST lock releases.
- Header on NORTH with dst(2,1) -> forwarded on SOUTH one cycle later. EAST and WEST outputs stay idle.
- Contention: NORTH and WEST headers to dst(1,3) arrive in the same cycle -> NORTH wins. WEST is held (its ack drops after BUF_DEPTH flits) until NORTH's tail leaves, then WEST is forwarded.
- Backpressure: out_ack_i[EAST]=0 while WEST streams -> out_flit_o held stable and in_ack_o[WEST]=0 after 2 accepted flits. Setting out_ack_i=1 resumes with no loss or duplication.
- Misc: dst(1,1) -> local_enable_o=1. A BODY flit on idle SOUTH -> discarded, err_o=1 the next cycle.

Source files
------------

// File: rtl/noc_node_if.sv
// noc_node_if: link bundle for one router node (four mesh links plus the local
// ejection port). The router side uses the slave modport.
interface noc_node_if #(
  parameter int FLIT_W = 32
);
  logic [3:0][FLIT_W-1:0] in_flit_i;
  logic [3:0]             in_enable_i;
  logic [3:0]             in_ack_o;
  logic [3:0][FLIT_W-1:0] out_flit_o;
  logic [3:0]             out_enable_o;
  logic [3:0]             out_ack_i;
  logic [FLIT_W-1:0]      local_flit_o;
  logic                   local_enable_o;
  logic                   local_ack_i;

  modport slave (
    input  in_flit_i, in_enable_i, out_ack_i, local_ack_i,
    output in_ack_o, out_flit_o, out_enable_o, local_flit_o, local_enable_o
  );

  modport master (
    output in_flit_i, in_enable_i, out_ack_i, local_ack_i,
    input  in_ack_o, out_flit_o, out_enable_o, local_flit_o, local_enable_o
  );
endinterface

// File: rtl/noc_node.sv
// noc_node: five-port wormhole mesh router, Y-then-X dimension-order routing,
// one input FIFO per link, round-robin arbiter per output.
// Port/output index: NORTH=0, SOUTH=1, EAST=2, WEST=3, LOCAL=4.
// Optional macro PKT_CNT_EN adds pkt_cnt_o, a 16-bit header counter per output.
module noc_node #(
  parameter int X_POS     = 1,
  parameter int Y_POS     = 1,
  parameter int ADDR_W    = 4,
  parameter int LEN_W     = 4,
  parameter int PAYLOAD_W = 30,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  noc_node_if.slave       bus,
  output logic            err_o
`ifdef PKT_CNT_EN
  ,
  output logic [4:0][15:0] pkt_cnt_o
`endif
);
  localparam int FLIT_W = PAYLOAD_W + 2;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int RW     = LEN_W + 1;
  localparam logic [1:0] HDR = 2'b01;
  localparam logic [2:0] R_N = 3'd0, R_S = 3'd1, R_E = 3'd2, R_W = 3'd3, R_L = 3'd4;
  localparam logic [ADDR_W-1:0] X_L = ADDR_W'(X_POS);
  localparam logic [ADDR_W-1:0] Y_L = ADDR_W'(Y_POS);

  logic [3:0][BUF_DEPTH-1:0][FLIT_W-1:0] mem_q, mem_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  // Per-output lock: owning input and flits still to leave (header included).
  logic [4:0]        own_vld_q, own_vld_d;
  logic [4:0][1:0]   own_q, own_d;
  logic [4:0][1:0]   rr_q, rr_d;
  logic [4:0][RW-1:0] rem_q, rem_d;
  logic              err_q, err_d;

  logic [3:0][FLIT_W-1:0] head;
  logic [3:0][ADDR_W-1:0] dst_x, dst_y;
  logic [3:0][LEN_W-1:0]  hlen;
  logic [3:0][2:0]        route;
  logic [3:0] nonempty, is_hdr, locked, in_ack, push, pop, drop;
  logic [4:0] grant, oen, xfer, ack_all;
  logic [4:0][1:0]        src;
  logic [4:0][RW-1:0]     rem_cur, rem_nxt;
  logic [4:0][FLIT_W-1:0] oflit;

  // Decode each FIFO head: header fields, route, lock status, push/drop.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head[i]     = mem_q[i][0];
      nonempty[i] = (cnt_q[i] != '0);
      is_hdr[i]   = (head[i][FLIT_W-1 -: 2] == HDR);
      dst_x[i]    = head[i][2*ADDR_W+LEN_W-1 -: ADDR_W];
      dst_y[i]    = head[i][ADDR_W+LEN_W-1 -: ADDR_W];
      hlen[i]     = head[i][LEN_W-1:0];
      in_ack[i]   = rst && (cnt_q[i] < CNT_W'(BUF_DEPTH));
      push[i]     = bus.in_enable_i[i] && in_ack[i];
      locked[i]   = 1'b0;
      for (int o = 0; o < 5; o++) begin
        if (own_vld_q[o] && (own_q[o] == 2'(i))) locked[i] = 1'b1;
      end
      if (dst_y[i] > Y_L)      route[i] = R_E;
      else if (dst_y[i] < Y_L) route[i] = R_W;
      else if (dst_x[i] > X_L) route[i] = R_S;
      else if (dst_x[i] < X_L) route[i] = R_N;
      else                     route[i] = R_L;
      // Stray non-header flits at an unlocked head are thrown away.
      drop[i] = nonempty[i] && !locked[i] && !is_hdr[i];
    end
  end

  // Per-output arbitration, crossbar selection and lock bookkeeping.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    ack_all   = {bus.local_ack_i, bus.out_ack_i};
    pop       = drop;
    own_vld_d = own_vld_q;
    own_d     = own_q;
    rem_d     = rem_q;
    rr_d      = rr_q;
    err_d     = err_q | (|drop);
    for (int o = 0; o < 5; o++) begin
      grant[o]   = 1'b0;
      src[o]     = own_q[o];
      rem_cur[o] = rem_q[o];
      if (!own_vld_q[o]) begin
        for (int k = 0; k < 4; k++) begin
          idx = rr_q[o] + 2'(k);
          if (!grant[o] && nonempty[idx] && is_hdr[idx] && !locked[idx] &&
              (route[idx] == 3'(o))) begin
            grant[o]   = 1'b1;
            src[o]     = idx;
            rem_cur[o] = RW'(hlen[idx]) + RW'(1);
          end
        end
      end
      oen[o]     = rst && (own_vld_q[o] || grant[o]) && nonempty[src[o]];
      xfer[o]    = oen[o] && ack_all[o];
      oflit[o]   = oen[o] ? head[src[o]] : '0;
      rem_nxt[o] = rem_cur[o] - RW'(xfer[o]);
      if (own_vld_q[o] || grant[o]) begin
        own_vld_d[o] = (rem_nxt[o] != '0);
        own_d[o]     = src[o];
        rem_d[o]     = rem_nxt[o];
      end
      if (grant[o]) rr_d[o] = src[o] + 2'd1;
      if (xfer[o])  pop[src[o]] = 1'b1;
    end
  end

  // FIFO storage: shift down on pop, write behind the surviving entries on push.
  always_comb begin
    logic [CNT_W-1:0] widx;
    widx  = '0;
    mem_d = mem_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) begin
        for (int j = 0; j < BUF_DEPTH - 1; j++) mem_d[i][j] = mem_q[i][j+1];
      end
      widx = cnt_q[i] - CNT_W'(pop[i]);
      if (push[i]) begin
        for (int j = 0; j < BUF_DEPTH; j++) begin
          if (CNT_W'(j) == widx) mem_d[i][j] = bus.in_flit_i[i];
        end
      end
      cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
  end

  // Control state; reset drops everything buffered or in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      own_vld_q <= '0;
      own_q     <= '0;
      rem_q     <= '0;
      rr_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      own_vld_q <= own_vld_d;
      own_q     <= own_d;
      rem_q     <= rem_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
    end
  end

  // Flit storage needs no reset; the counts qualify it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef PKT_CNT_EN
  logic [4:0][15:0] pkt_cnt_q;

  // Count header flits leaving each output; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_cnt_q <= '0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (xfer[o] && (oflit[o][FLIT_W-1 -: 2] == HDR)) pkt_cnt_q[o] <= pkt_cnt_q[o] + 16'd1;
      end
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

  assign bus.in_ack_o       = in_ack;
  assign bus.out_enable_o   = oen[3:0];
  assign bus.out_flit_o     = oflit[3:0];
  assign bus.local_enable_o = oen[4];
  assign bus.local_flit_o   = oflit[4];
  assign err_o              = err_q;
endmodule

// File: tb/tb_noc_node.sv
// tb_noc_node: directed bench for noc_node (X_POS=1, Y_POS=1, 32-bit flits).
module tb_noc_node;
  typedef logic [31:0] flit_t;
  typedef struct {
    int port;
    int dx;
    int dy;
    int exp_out;
  } vec_t;

  localparam logic [1:0] T_H = 2'b01, T_B = 2'b10, T_T = 2'b11;
  localparam int PN = 0, PS = 1, PE = 2, PW = 3, PL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err;

  noc_node_if #(.FLIT_W(32)) bus ();

  noc_node dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .err_o (err)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  flit_t q_in [4][$];
  flit_t obs[$];
  int    obs_cyc[$];
  int    stall_acc;
  flit_t held;
  vec_t  tv[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic flit_t mk(input logic [1:0] t, input int dx, input int dy,
                               input int ln, input int tag);
    flit_t f;
    f        = '0;
    f[31:30] = t;
    f[29:12] = tag[17:0];
    f[11:8]  = dx[3:0];
    f[7:4]   = dy[3:0];
    f[3:0]   = ln[3:0];
    return f;
  endfunction

  function automatic logic [4:0] oen5();
    return {bus.local_enable_o, bus.out_enable_o};
  endfunction

  function automatic flit_t outf(input int p);
    logic [1:0] pi;
    pi = p[1:0];
    if (p == PL) return bus.local_flit_o;
    return bus.out_flit_o[pi];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.in_enable_i = '0;
    bus.out_ack_i   = '1;
    bus.local_ack_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Streams q_in into the DUT, watching output osel; its ack is held low for
  // the first 'stall' cycles. Records flits leaving osel and the number of
  // flits accepted on 'watch' before its ack first dropped.
  task automatic run(input int osel, input int stall, input int watch, input int ncyc);
    logic [3:0] acc;
    logic       oe;
    flit_t      of;
    bit         have_held;
    int         nacc;
    obs.delete();
    obs_cyc.delete();
    stall_acc = -1;
    have_held = 0;
    nacc      = 0;
    held      = '0;
    for (int c = 0; c < ncyc; c++) begin
      for (int p = 0; p < 4; p++) begin
        if (q_in[p].size() > 0) begin
          bus.in_enable_i[p] = 1'b1;
          bus.in_flit_i[p]   = q_in[p][0];
        end else begin
          bus.in_enable_i[p] = 1'b0;
          bus.in_flit_i[p]   = '0;
        end
      end
      bus.out_ack_i   = 4'hf;
      bus.local_ack_i = 1'b1;
      if (c < stall) begin
        if (osel == PL) bus.local_ack_i = 1'b0;
        else bus.out_ack_i[osel] = 1'b0;
      end
      #1;
      acc = bus.in_enable_i & bus.in_ack_o;
      if (!bus.in_ack_o[watch] && stall_acc < 0) stall_acc = nacc;
      oe = (osel == PL) ? bus.local_enable_o : bus.out_enable_o[osel];
      of = outf(osel);
      if (c < stall && oe) begin
        if (!have_held) begin
          held      = of;
          have_held = 1;
        end else begin
          check("stall_hold", of, held);
        end
      end
      if (oe && c >= stall) begin
        obs.push_back(of);
        obs_cyc.push_back(c);
      end
      @(posedge clk);
      for (int p = 0; p < 4; p++) if (acc[p]) void'(q_in[p].pop_front());
      if (acc[watch]) nacc++;
      @(negedge clk);
    end
    bus.in_enable_i = '0;
  endtask

  task automatic cmp_stream(input string name, input flit_t exp[$]);
    check({name, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++) check(name, obs[i], exp[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    flit_t f;
    flit_t exp[$];
    int    e;

    tv[0] = '{PW, 1, 3, PE};
    tv[1] = '{PN, 2, 1, PS};
    tv[2] = '{PE, 1, 0, PW};
    tv[3] = '{PS, 0, 1, PN};
    tv[4] = '{PN, 1, 1, PL};
    tv[5] = '{PE, 0, 0, PW};
    tv[6] = '{PW, 3, 2, PE};
    tv[7] = '{PS, 15, 1, PS};
    tv[8] = '{PN, 0, 15, PE};

    bus.in_flit_i   = '0;
    bus.in_enable_i = '0;
    bus.out_ack_i   = '1;
    bus.local_ack_i = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ack", bus.in_ack_o, 4'h0);
    check("rst_out_en", oen5(), 5'h0);
    check("rst_err", err, 1'b0);
    check("rst_out_flit", bus.out_flit_o[2], 32'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ack", bus.in_ack_o, 4'hf);

    // WEST packet of 4 flits to (1,3) leaves on EAST on consecutive cycles
    exp.delete();
    exp.push_back(mk(T_H, 1, 3, 3, 1));
    exp.push_back(mk(T_B, 0, 0, 0, 2));
    exp.push_back(mk(T_B, 0, 0, 0, 3));
    exp.push_back(mk(T_T, 0, 0, 0, 4));
    foreach (exp[i]) q_in[PW].push_back(exp[i]);
    run(PE, 0, PW, 10);
    cmp_stream("w2e_stream", exp);
    if (obs_cyc.size() == 4) begin
      check("w2e_first_cycle", obs_cyc[0], 1);
      check("w2e_consecutive", obs_cyc[3] - obs_cyc[0], 3);
    end
    check("w2e_idle_after", oen5(), 5'h0);

    // backpressure on EAST while WEST streams
    exp.delete();
    exp.push_back(mk(T_H, 1, 3, 3, 11));
    exp.push_back(mk(T_B, 0, 0, 0, 12));
    exp.push_back(mk(T_B, 0, 0, 0, 13));
    exp.push_back(mk(T_T, 0, 0, 0, 14));
    foreach (exp[i]) q_in[PW].push_back(exp[i]);
    run(PE, 6, PW, 14);
    check("bp_held_flit", held, exp[0]);
    check("bp_ack_drop_after", stall_acc, 2);
    cmp_stream("bp_stream", exp);

    // single-header routing table, tail_length=0
    bus.out_ack_i   = '1;
    bus.local_ack_i = 1'b1;
    for (int v = 0; v < 9; v++) begin
      f = mk(T_H, tv[v].dx, tv[v].dy, 0, 100 + v);
      bus.in_flit_i[tv[v].port]   = f;
      bus.in_enable_i[tv[v].port] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_enable_i = '0;
      e = 1 << tv[v].exp_out;
      check("route_enable", oen5(), 32'(e));
      check("route_flit", outf(tv[v].exp_out), f);
      @(posedge clk);
      @(negedge clk);
      check("route_idle", oen5(), 5'h0);
    end

    // contention: NORTH and WEST to (1,3) in the same cycle, NORTH wins
    do_reset();
    exp.delete();
    exp.push_back(mk(T_H, 1, 3, 2, 21));
    exp.push_back(mk(T_B, 0, 0, 0, 22));
    exp.push_back(mk(T_T, 0, 0, 0, 23));
    foreach (exp[i]) q_in[PN].push_back(exp[i]);
    exp.push_back(mk(T_H, 1, 3, 2, 31));
    exp.push_back(mk(T_B, 0, 0, 0, 32));
    exp.push_back(mk(T_T, 0, 0, 0, 33));
    for (int i = 3; i < 6; i++) q_in[PW].push_back(exp[i]);
    run(PE, 0, PW, 14);
    cmp_stream("contend_stream", exp);
    check("contend_w_ack_drop", stall_acc, 2);
    if (obs_cyc.size() == 6) check("contend_release_gap", obs_cyc[3] - obs_cyc[2], 1);

    // stray BODY on idle SOUTH is discarded and flags err_o
    @(negedge clk);
    bus.in_flit_i[PS]   = mk(T_B, 1, 3, 0, 41);
    bus.in_enable_i[PS] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_enable_i = '0;
    check("err_not_forwarded", oen5(), 5'h0);
    @(posedge clk);
    @(negedge clk);
    check("err_set", err, 1'b1);
    check("err_fifo_empty_no_out", oen5(), 5'h0);
    @(posedge clk);
    @(negedge clk);
    check("err_sticky", err, 1'b1);

    // reset with a packet parked at an output drops it
    bus.out_ack_i       = 4'b1011;
    bus.in_flit_i[PW]   = mk(T_H, 1, 3, 3, 51);
    bus.in_enable_i[PW] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_enable_i = '0;
    check("park_presented", oen5(), 5'b00100);
    rst = 1'b0;
    #1;
    check("rst_gates_out", oen5(), 5'h0);
    check("rst_gates_ack", bus.in_ack_o, 4'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst_clears_err", err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ack_i = 4'hf;
    @(posedge clk);
    @(negedge clk);
    check("rst_dropped_pkt", oen5(), 5'h0);
    check("rst_release_ack", bus.in_ack_o, 4'hf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
